aurora_tx_arbiter: RTL
======================

// Module: aurora_tx_arbiter
// PURPOSE
//  Packet-atomic scheduler for the single Aurora TX AXI-Stream port. Shares it between
//  the host path (output of pre, seq-numbered) and the loopback FIFO, replacing the
//  combinational loopback mux. The source is switched only on packet boundaries.
//  Nothing is sent while channel_up is low. A packet cut by link loss is drained and counted.
// PARAMETERS
//  DATA_WIDTH  32  tdata width, all streams
//  CNT_WIDTH   16  width of the saturating statistics counters
// PORTS
//  user_clk        in   1           Aurora user clock, sole clock
//  sys_reset       in   1           synchronous, active-high reset
//  channel_up      in   1           Aurora channel status, synchronous to user_clk
//  mode            in   2           00 host only, 01 loopback only, 10 round-robin, 11 pause
//  cnt_clear       in   1           1-cycle pulse, zeroes all counters
//  s0_axis_tvalid  in   1           host stream (from pre)
//  s0_axis_tdata   in   DATA_WIDTH
//  s0_axis_tlast   in   1
//  s0_axis_tready  out  1
//  s1_axis_*       same as s0_*     loopback stream (from fifo_loop)
//  m_axis_tvalid   out  1           to Aurora s_axi_tx_*
//  m_axis_tdata    out  DATA_WIDTH
//  m_axis_tlast    out  1
//  m_axis_tready   in   1
//  grant           out  2           one-hot current owner (01 = s0, 10 = s1), 00 when idle
//  busy            out  1           state != IDLE
//  pkt_cnt0        out  CNT_WIDTH   packets completed from s0
//  pkt_cnt1        out  CNT_WIDTH   packets completed from s1
//  abort_cnt       out  CNT_WIDTH   packets drained after link loss
// BEHAVIOUR
//  Reset: state = IDLE; grant = 00; rr_last = s1 (so s0 wins first); all counters = 0.
//   All tready/tvalid outputs = 0 and m_axis_tdata = 0 while state = IDLE.
//  FSM, registered:
//   IDLE:  when channel_up = 1 and mode != 11, pick an eligible source with tvalid = 1.
//    mode 00 -> s0 only; mode 01 -> s1 only.
//    mode 10 -> if both valid, take the source != rr_last; else whichever is valid.
//    Load grant and go to XFER. Arbitration costs exactly 1 cycle; no beat moves in IDLE.
//   XFER:  combinational pass-through of the granted source, zero data latency.
//    m_axis_tvalid = sG_tvalid & channel_up; sG_tready = m_axis_tready & channel_up.
//    The non-granted tready = 0.
//    On sG_tvalid & sG_tready & sG_tlast: ++pkt_cntG, rr_last <= G, go to IDLE.
//    If channel_up = 0 (sampled), go to DRAIN; same cycle, outputs are already gated off.
//    This takes priority over a simultaneous last beat: that beat is not accepted.
//   DRAIN: m_axis_tvalid = 0; sG_tready = 1, beats are discarded.
//    On sG_tvalid & sG_tlast: ++abort_cnt, go to IDLE.
//    If the packet had not started (no beat accepted yet), it is still drained whole.
//  mode changes mid-packet have no effect until the next IDLE; mode 11 finishes the current packet.
//  Counters: saturate at all-ones, no wrap. cnt_clear has priority over a same-cycle
//   increment (result 0). Clear does not disturb the FSM.
//  sys_reset mid-packet: immediate return to IDLE. The partial upstream packet is the
//   upstream block's concern; no abort is counted.
//  back-to-back: minimum 1 idle cycle between packets (IDLE arbitration cycle).
//  Single-beat packet (tlast on first beat) is legal; XFER lasts 1 cycle when tready = 1.
// TESTING
//  1 mode = 10, both sources hold 4-beat packets, tready = 1
//    -> order s0,s1,s0,s1; 4 data cycles + 1 idle per packet; pkt_cnt0 = pkt_cnt1 = 2.
//  2 mode 00 -> 01 written during beat 2 of a 6-beat s0 packet
//    -> all 6 s0 beats out contiguous; next grant = 10; no s1 beat interleaved.
//  3 channel_up dropped after beat 3 of an 8-beat s1 packet
//    -> m_axis_tvalid = 0 that cycle; beats 4..8 consumed with s1_tready = 1;
//       abort_cnt = 1; s1 count unchanged; no grant until channel_up = 1.
//  4 m_axis_tready toggles 1,0,0,1 during a 3-beat s0 packet
//    -> tdata/tlast held stable while stalled; exactly 3 handshakes; pkt_cnt0 = 1.
//  5 pkt_cnt0 preset near max (CNT_WIDTH = 4, 15 packets), send 2 more
//    -> stays 4'hF; cnt_clear with a same-cycle last beat -> 0.
//  6 sys_reset asserted mid-XFER, then released
//    -> next cycle: grant = 00, busy = 0, all counters 0, all tready = 0; s0 wins first rr grant.

Source files
------------

// File: rtl/aurora_tx_arbiter_if.sv
// AXI-Stream bundle shared by the host, loopback and Aurora TX sides
// of the TX arbiter.
interface aurora_tx_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  tvalid;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
    logic                  tready;

    modport master (
        output tvalid, tdata, tlast,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tlast,
        output tready
    );
endinterface

// File: rtl/aurora_tx_arbiter.sv
// Packet-atomic scheduler for the Aurora TX stream: host (s0) vs loopback (s1),
// switching only on packet boundaries, draining packets cut by link loss.
module aurora_tx_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 user_clk,
    input  logic                 sys_reset,
    input  logic                 channel_up,
    input  logic [1:0]           mode,
    input  logic                 cnt_clear,
    aurora_tx_arbiter_if.slave   s0_axis,
    aurora_tx_arbiter_if.slave   s1_axis,
    aurora_tx_arbiter_if.master  m_axis,
    output logic [1:0]           grant,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] pkt_cnt0,
    output logic [CNT_WIDTH-1:0] pkt_cnt1,
    output logic [CNT_WIDTH-1:0] abort_cnt
);

    typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_e;

    state_e               state_q, state_d;
    logic [1:0]           grant_q, grant_d;
    logic                 rr_last_q, rr_last_d;
    logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d;
    logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;
    logic [CNT_WIDTH-1:0] abort_q, abort_d;

    logic                  g_sel;
    logic                  g_valid;
    logic                  g_last;
    logic [DATA_WIDTH-1:0] g_data;
    logic                  pick0, pick1;
    logic                  inc0, inc1, inc_ab;

    // rr_last_q = 1 means s1 was served last
    assign g_sel   = grant_q[1];
    assign g_valid = g_sel ? s1_axis.tvalid : s0_axis.tvalid;
    assign g_last  = g_sel ? s1_axis.tlast  : s0_axis.tlast;
    assign g_data  = g_sel ? s1_axis.tdata  : s0_axis.tdata;

    assign pick0 = s0_axis.tvalid &&
                   (mode == 2'b00 ||
                    (mode == 2'b10 && (!s1_axis.tvalid || rr_last_q)));
    assign pick1 = s1_axis.tvalid &&
                   (mode == 2'b01 ||
                    (mode == 2'b10 && (!s0_axis.tvalid || !rr_last_q)));

    function automatic logic [CNT_WIDTH-1:0] sat_inc(
        input logic [CNT_WIDTH-1:0] v,
        input logic                 en
    );
        return (en && v != '1) ? v + 1'b1 : v;
    endfunction

    always_ff @(posedge user_clk) begin
        if (sys_reset) begin
            state_q   <= IDLE;
            grant_q   <= 2'b00;
            rr_last_q <= 1'b1;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
            abort_q   <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_last_q <= rr_last_d;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
            abort_q   <= abort_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_last_d = rr_last_q;
        inc0      = 1'b0;
        inc1      = 1'b0;
        inc_ab    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (channel_up && mode != 2'b11) begin
                    if (pick0) begin
                        grant_d = 2'b01;
                        state_d = XFER;
                    end else if (pick1) begin
                        grant_d = 2'b10;
                        state_d = XFER;
                    end
                end
            end
            XFER: begin
                // link loss wins over a same-cycle last beat
                if (!channel_up) begin
                    state_d = DRAIN;
                end else if (g_valid && m_axis.tready && g_last) begin
                    state_d   = IDLE;
                    grant_d   = 2'b00;
                    rr_last_d = g_sel;
                    inc0      = !g_sel;
                    inc1      = g_sel;
                end
            end
            DRAIN: begin
                if (g_valid && g_last) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                    inc_ab  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
        cnt0_d  = cnt_clear ? '0 : sat_inc(cnt0_q, inc0);
        cnt1_d  = cnt_clear ? '0 : sat_inc(cnt1_q, inc1);
        abort_d = cnt_clear ? '0 : sat_inc(abort_q, inc_ab);
    end

    always_comb begin
        m_axis.tvalid  = 1'b0;
        m_axis.tdata   = '0;
        m_axis.tlast   = 1'b0;
        s0_axis.tready = 1'b0;
        s1_axis.tready = 1'b0;
        unique case (state_q)
            XFER: begin
                m_axis.tvalid  = g_valid & channel_up;
                m_axis.tdata   = g_data;
                m_axis.tlast   = g_last;
                s0_axis.tready = !g_sel & m_axis.tready & channel_up;
                s1_axis.tready = g_sel & m_axis.tready & channel_up;
            end
            DRAIN: begin
                s0_axis.tready = !g_sel;
                s1_axis.tready = g_sel;
            end
            default: ;
        endcase
    end

    assign grant     = grant_q;
    assign busy      = (state_q != IDLE);
    assign pkt_cnt0  = cnt0_q;
    assign pkt_cnt1  = cnt1_q;
    assign abort_cnt = abort_q;

endmodule
